// File: rtl/axi_lite_timer_pkg.sv
// Shared definitions for the AXI4-Lite timer: register offsets, bit indices, reset values, responses.
// The optional prescaler is controlled by the AXI_LITE_TIMER_PRESCALER_EN macro.
package axi_lite_timer_pkg;

  localparam logic [11:0] OFF_CTRL     = 12'h000;
  localparam logic [11:0] OFF_STATUS   = 12'h004;
  localparam logic [11:0] OFF_COUNT    = 12'h008;
  localparam logic [11:0] OFF_COMPARE  = 12'h00C;
  localparam logic [11:0] OFF_PRESCALE = 12'h010;

  // Word indices as decoded from addr[11:2]
  localparam logic [9:0] IDX_CTRL     = OFF_CTRL[11:2];
  localparam logic [9:0] IDX_STATUS   = OFF_STATUS[11:2];
  localparam logic [9:0] IDX_COUNT    = OFF_COUNT[11:2];
  localparam logic [9:0] IDX_COMPARE  = OFF_COMPARE[11:2];
  localparam logic [9:0] IDX_PRESCALE = OFF_PRESCALE[11:2];

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_RELOAD  = 2;
  localparam int STATUS_MATCH = 0;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  // Mirrors the SoC-wide AXI response encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/axi_lite_timer_core.sv
// Timer datapath: optional prescaler, 32-bit counter, compare and sticky MATCH flag.
// Prescaler logic exists only when AXI_LITE_TIMER_PRESCALER_EN is defined.
module axi_lite_timer_core
  import axi_lite_timer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en,
  input  logic        reload,
  input  logic [31:0] compare,
  input  logic [15:0] prescale,
  input  logic        prescale_we,
  input  logic        count_we,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        match_clr,
  output logic [31:0] count,
  output logic        match
);

  logic tick;
  logic hit;

`ifdef AXI_LITE_TIMER_PRESCALER_EN
  logic [15:0] pre_cnt;

  assign tick = en && (pre_cnt == prescale);

  // A PRESCALE write restarts the divide period
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          pre_cnt <= '0;
    else if (prescale_we) pre_cnt <= '0;
    else if (en)          pre_cnt <= tick ? '0 : pre_cnt + 16'd1;
  end
`else
  logic prescale_unused;
  assign prescale_unused = ^{prescale, prescale_we};
  assign tick = en;
`endif

  assign hit = tick && (count == compare);

  // Software writes take priority over the tick
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       count <= '0;
    else if (count_we) count <= apply_strb(count, wdata, wstrb);
    else if (tick)     count <= (hit && reload) ? '0 : count + 32'd1;
  end

  // Hardware set wins over a simultaneous W1C
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) match <= 1'b0;
    else         match <= hit | (match & ~match_clr);
  end

endmodule

// File: rtl/axi_lite_timer.sv
// AXI4-Lite timer peripheral: register front-end, one write outstanding, registered read data.
// Define AXI_LITE_TIMER_PRESCALER_EN to include the PRESCALE register and prescaler.
module axi_lite_timer
  import axi_lite_timer_pkg::*;
#(
  parameter int ADDR_BW_p = 16,
  parameter int DATA_BW_p = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [ADDR_BW_p-1:0]   s_awaddr_i,
  input  logic                   s_awvalid_i,
  output logic                   s_awready_o,
  input  logic [DATA_BW_p-1:0]   s_wdata_i,
  input  logic [DATA_BW_p/8-1:0] s_wstrb_i,
  input  logic                   s_wvalid_i,
  output logic                   s_wready_o,
  output logic [1:0]             s_bresp_o,
  output logic                   s_bvalid_o,
  input  logic                   s_bready_i,
  input  logic [ADDR_BW_p-1:0]   s_araddr_i,
  input  logic                   s_arvalid_i,
  output logic                   s_arready_o,
  output logic [DATA_BW_p-1:0]   s_rdata_o,
  output logic [1:0]             s_rresp_o,
  output logic                   s_rvalid_o,
  input  logic                   s_rready_i,
  output logic                   irq_o
);

  if (DATA_BW_p != 32) begin : g_bw_check
    $error("axi_lite_timer: only DATA_BW_p == 32 is supported");
  end

  logic addr_unused;
  assign addr_unused = ^{s_awaddr_i[ADDR_BW_p-1:12], s_awaddr_i[1:0],
                         s_araddr_i[ADDR_BW_p-1:12], s_araddr_i[1:0]};

  // ---------------- write channel capture ----------------
  logic        aw_q, w_q, bvalid_q;
  logic [1:0]  bresp_q;
  logic [9:0]  aw_idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_hs, w_hs, wr_fire, wr_ok;
  logic [9:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  assign s_awready_o = !aw_q;
  assign s_wready_o  = !w_q;
  assign aw_hs       = s_awvalid_i && !aw_q;
  assign w_hs        = s_wvalid_i && !w_q;
  // Commit on the edge where the second half arrives, using live inputs if not yet captured
  assign wr_fire     = (aw_q || aw_hs) && (w_q || w_hs) && !bvalid_q;
  assign wr_idx      = aw_q ? aw_idx_q : s_awaddr_i[11:2];
  assign wr_data     = w_q ? wdata_q : s_wdata_i;
  assign wr_strb     = w_q ? wstrb_q : s_wstrb_i;
  assign wr_ok       = (wr_idx <= IDX_PRESCALE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_q     <= 1'b0;
      w_q      <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (aw_hs) begin
        aw_q     <= 1'b1;
        aw_idx_q <= s_awaddr_i[11:2];
      end
      if (w_hs) begin
        w_q     <= 1'b1;
        wdata_q <= s_wdata_i;
        wstrb_q <= s_wstrb_i;
      end
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && s_bready_i) begin
        bvalid_q <= 1'b0;
        aw_q     <= 1'b0;
        w_q      <= 1'b0;
      end
    end
  end

  assign s_bvalid_o = bvalid_q;
  assign s_bresp_o  = bresp_q;

  // ---------------- registers ----------------
  logic [2:0]  ctrl_q;
  logic [31:0] compare_q;
  logic [15:0] prescale_val;
  logic [31:0] count;
  logic        match;
  logic        ctrl_we, status_we, count_we, compare_we, prescale_we, match_clr;

  assign ctrl_we     = wr_fire && (wr_idx == IDX_CTRL);
  assign status_we   = wr_fire && (wr_idx == IDX_STATUS);
  assign count_we    = wr_fire && (wr_idx == IDX_COUNT);
  assign compare_we  = wr_fire && (wr_idx == IDX_COMPARE);
  assign prescale_we = wr_fire && (wr_idx == IDX_PRESCALE);
  assign match_clr   = status_we && wr_strb[0] && wr_data[STATUS_MATCH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q    <= '0;
      compare_q <= COMPARE_RST;
    end else begin
      if (ctrl_we && wr_strb[0]) ctrl_q <= wr_data[2:0];
      if (compare_we)            compare_q <= apply_strb(compare_q, wr_data, wr_strb);
    end
  end

`ifdef AXI_LITE_TIMER_PRESCALER_EN
  logic [15:0] prescale_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prescale_q <= '0;
    else if (prescale_we) begin
      if (wr_strb[0]) prescale_q[7:0]  <= wr_data[7:0];
      if (wr_strb[1]) prescale_q[15:8] <= wr_data[15:8];
    end
  end
  assign prescale_val = prescale_q;
`else
  assign prescale_val = '0;
`endif

  axi_lite_timer_core u_core (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en          (ctrl_q[CTRL_EN]),
    .reload      (ctrl_q[CTRL_RELOAD]),
    .compare     (compare_q),
    .prescale    (prescale_val),
    .prescale_we (prescale_we),
    .count_we    (count_we),
    .wdata       (wr_data),
    .wstrb       (wr_strb),
    .match_clr   (match_clr),
    .count       (count),
    .match       (match)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_o <= 1'b0;
    else         irq_o <= match & ctrl_q[CTRL_IRQ_EN];
  end

  // ---------------- read channel ----------------
  logic        rvalid_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q, rd_data;
  logic        rd_ok, ar_hs;

  assign s_arready_o = !rvalid_q;
  assign ar_hs       = s_arvalid_i && !rvalid_q;

  always_comb begin
    rd_data = '0;
    rd_ok   = 1'b1;
    case (s_araddr_i[11:2])
      IDX_CTRL:     rd_data = {29'd0, ctrl_q};
      IDX_STATUS:   rd_data = {31'd0, match};
      IDX_COUNT:    rd_data = count;
      IDX_COMPARE:  rd_data = compare_q;
      IDX_PRESCALE: rd_data = {16'd0, prescale_val};
      default:      rd_ok   = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && s_rready_i) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_rvalid_o = rvalid_q;
  assign s_rdata_o  = rdata_q;
  assign s_rresp_o  = rresp_q;

endmodule

// File: tb/tb_axi_lite_timer.sv
// Directed scoreboard bench for axi_lite_timer; expected responses are queued at issue and popped at response.
`timescale 1ns/1ps
module tb_axi_lite_timer;
  import axi_lite_timer_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  axi_lite_timer #(.ADDR_BW_p(16), .DATA_BW_p(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_awaddr_i(awaddr), .s_awvalid_i(awvalid), .s_awready_o(awready),
    .s_wdata_i(wdata), .s_wstrb_i(wstrb), .s_wvalid_i(wvalid), .s_wready_o(wready),
    .s_bresp_o(bresp), .s_bvalid_o(bvalid), .s_bready_i(bready),
    .s_araddr_i(araddr), .s_arvalid_i(arvalid), .s_arready_o(arready),
    .s_rdata_o(rdata), .s_rresp_o(rresp), .s_rvalid_o(rvalid), .s_rready_i(rready),
    .irq_o(irq)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int last_wr_cyc = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] er, input string tag);
    int n;
    logic aw_hs, w_hs;
    bq.push_back(er);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk_i); #1; n++;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    last_wr_cyc = cyc;
    n = 0;
    while (!bvalid && n < 20) begin @(posedge clk_i); #1; n++; end
    chk({tag, " bvalid"}, 32'(bvalid), 32'd1);
    chk({tag, " bresp"}, 32'(bresp), 32'(bq.pop_front()));
    bready = 1'b1; @(posedge clk_i); #1; bready = 1'b0;
  endtask

  task automatic axi_read(input logic [15:0] a, input logic [31:0] ed, input logic [1:0] er,
                          input string tag);
    int n;
    logic hs;
    logic [33:0] e;
    rq.push_back({er, ed});
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (arvalid && n < 20) begin
      hs = arready;
      @(posedge clk_i); #1; n++;
      if (hs) arvalid = 1'b0;
    end
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(posedge clk_i); #1; n++; end
    chk({tag, " rvalid"}, 32'(rvalid), 32'd1);
    e = rq.pop_front();
    chk({tag, " rdata"}, rdata, e[31:0]);
    chk({tag, " rresp"}, 32'(rresp), 32'(e[33:32]));
    rready = 1'b1; @(posedge clk_i); #1; rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, c1, c2, c3, c4, n;
    logic [31:0] e32;

    // reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst awready", 32'(awready), 32'd1);
    chk("rst wready",  32'(wready),  32'd1);
    chk("rst arready", 32'(arready), 32'd1);
    chk("rst bvalid",  32'(bvalid),  32'd0);
    chk("rst rvalid",  32'(rvalid),  32'd0);
    chk("rst irq",     32'(irq),     32'd0);
    chk("rst rdata",   rdata,        32'd0);
    chk("rst bresp",   32'(bresp),   32'(RESP_OKAY));
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    axi_read(16'h100C, 32'hFFFF_FFFF, RESP_OKAY, "compare reset");
    axi_read(16'h1014, 32'h0, RESP_SLVERR, "unmapped read");
    axi_write(16'h1014, 32'h1234_5678, 4'hF, RESP_SLVERR, "unmapped write");

    // W one cycle ahead of AW, bready held off for 3 cycles
    bq.push_back(RESP_OKAY);
    wdata = 32'hAABB_CCDD; wstrb = 4'b0010; wvalid = 1'b1;
    @(posedge clk_i); #1;
    wvalid = 1'b0;
    chk("tw wready low",  32'(wready),  32'd0);
    chk("tw awready hi",  32'(awready), 32'd1);
    chk("tw bvalid early", 32'(bvalid), 32'd0);
    awaddr = 16'h1008; awvalid = 1'b1;
    @(posedge clk_i); #1;
    awvalid = 1'b0;
    chk("tw bvalid", 32'(bvalid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      chk("tw bvalid held", 32'(bvalid), 32'd1);
      chk("tw awready held low", 32'(awready), 32'd0);
      chk("tw wready held low", 32'(wready), 32'd0);
    end
    chk("tw bresp", 32'(bresp), 32'(bq.pop_front()));
    bready = 1'b1;
    @(posedge clk_i); #1;
    bready = 1'b0;
    chk("tw bvalid drop", 32'(bvalid), 32'd0);
    chk("tw awready back", 32'(awready), 32'd1);
    chk("tw wready back", 32'(wready), 32'd1);
    axi_read(16'h1008, 32'h0000_CC00, RESP_OKAY, "count strobe");

    // compare match with reload, prescale 0
    axi_write(16'h100C, 32'd5, 4'hF, RESP_OKAY, "cmp=5");
    axi_write(16'h1010, 32'd0, 4'hF, RESP_OKAY, "pre=0");
    axi_write(16'h1008, 32'd0, 4'hF, RESP_OKAY, "count=0");
    axi_write(16'h1000, 32'hFFFF_FFFF, 4'hF, RESP_OKAY, "ctrl=all");
    c0 = last_wr_cyc;
    n = 0;
    while (!irq && n < 40) begin @(posedge clk_i); #1; n++; end
    chk("irq latency", 32'(cyc - c0), 32'd7);
    axi_read(16'h1000, 32'd7, RESP_OKAY, "ctrl readback");
    axi_read(16'h1004, 32'd1, RESP_OKAY, "status match");
    axi_read(16'h1008, 32'((cyc - c0) % 6), RESP_OKAY, "reload count");
    axi_write(16'h1000, 32'd0, 4'hF, RESP_OKAY, "ctrl=0");
    c1 = last_wr_cyc;
    axi_write(16'h1004, 32'd1, 4'h1, RESP_OKAY, "w1c");
    axi_read(16'h1004, 32'd0, RESP_OKAY, "status cleared");
    chk("irq cleared", 32'(irq), 32'd0);
    axi_read(16'h1008, 32'((c1 - c0) % 6), RESP_OKAY, "count frozen");

    // prescaler
    axi_write(16'h1008, 32'd0, 4'hF, RESP_OKAY, "count=0 b");
    axi_write(16'h1010, 32'd3, 4'hF, RESP_OKAY, "pre=3");
    axi_write(16'h1000, 32'd1, 4'hF, RESP_OKAY, "ctrl=en");
    c2 = last_wr_cyc;
    repeat (9) @(posedge clk_i);
    #1;
`ifdef AXI_LITE_TIMER_PRESCALER_EN
    axi_read(16'h1010, 32'd3, RESP_OKAY, "prescale read");
    axi_read(16'h1008, 32'((cyc - c2) / 4), RESP_OKAY, "prescaled count a");
    repeat (3) @(posedge clk_i);
    #1;
    axi_read(16'h1008, 32'((cyc - c2) / 4), RESP_OKAY, "prescaled count b");
`else
    axi_read(16'h1010, 32'd0, RESP_OKAY, "prescale read");
    axi_read(16'h1008, 32'(cyc - c2), RESP_OKAY, "prescaled count a");
    repeat (3) @(posedge clk_i);
    #1;
    axi_read(16'h1008, 32'(cyc - c2), RESP_OKAY, "prescaled count b");
`endif

    // wrap without reload, W1C colliding with a new match
    axi_write(16'h1000, 32'd0, 4'hF, RESP_OKAY, "ctrl off");
    axi_write(16'h1010, 32'd0, 4'hF, RESP_OKAY, "pre=0 b");
    axi_write(16'h100C, 32'hFFFF_FFFF, 4'hF, RESP_OKAY, "cmp=max");
    axi_write(16'h1008, 32'hFFFF_FFFE, 4'hF, RESP_OKAY, "count=max-1");
    axi_write(16'h1004, 32'd1, 4'h1, RESP_OKAY, "w1c pre");
    axi_write(16'h1000, 32'd1, 4'hF, RESP_OKAY, "ctrl=en b");
    c3 = last_wr_cyc;
    axi_write(16'h1004, 32'd1, 4'h1, RESP_OKAY, "w1c collide");
    chk("w1c edge", 32'(last_wr_cyc - c3), 32'd2);
    axi_write(16'h1000, 32'd0, 4'hF, RESP_OKAY, "ctrl off b");
    c4 = last_wr_cyc;
    axi_read(16'h1004, 32'd1, RESP_OKAY, "match survives w1c");
    e32 = 32'hFFFF_FFFE + 32'(c4 - c3);
    axi_read(16'h1008, e32, RESP_OKAY, "wrap count");
    chk("irq masked", 32'(irq), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
